crossbar_ctrl: RTL and testbench
================================

Name: crossbar_ctrl

Overview:
- Sequential controller that drives the `select` input of the 2x2 structural crossbar. `select`=0 is straight: in1->out1, in2->out2. `select`=1 is cross: in1->out2, in2->out1.
- Arbitrates two source requests, each carrying a destination output port.
- Holds the crossbar configuration for a fixed-length transfer.
- Flags which crossbar outputs carry valid data for the downstream consumer.

Parameters:
- PKT_LEN, 4, transfer length in clock cycles; must be >= 1.
- CNT_W, 3, width of the transfer counter; must hold PKT_LEN-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req1  input  1  source 1 (crossbar in1) requests a transfer.
- dest1  input  1  source 1 destination: 0 = out1, 1 = out2.
- req2  input  1  source 2 (crossbar in2) requests a transfer.
- dest2  input  1  source 2 destination: 0 = out1, 1 = out2.
- select  output  1  crossbar configuration, registered.
- grant1  output  1  source 1 may drive in1 this cycle.
- grant2  output  1  source 2 may drive in2 this cycle.
- out_valid1  output  1  crossbar out1 carries granted data.
- out_valid2  output  1  crossbar out2 carries granted data.
- busy  output  1  high while in XFER.
- done  output  1  one-cycle pulse in the first cycle after a transfer ends.

Behaviour:
- All outputs are registered.
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, counter 0, priority pointer = source 1;
  - select=0, grant1=grant2=0, out_valid1=out_valid2=0, busy=0, done=0.
- Release of reset is synchronous to the next clk edge.
- State IDLE, clock edge with neither req1 nor req2 high: stay in IDLE, all outputs 0 except `select`, which holds its last value.
- State IDLE, clock edge with a request present: go to XFER and load counter = PKT_LEN-1. Decision at that edge:
  - Only req1: grant1=1, select=dest1.
  - Only req2: grant2=1, select=~dest2.
  - Both, dest1 != dest2: grant1=grant2=1, select=dest1.
  - Both, dest1 == dest2 (conflict): grant only the source named by the priority pointer, with select as in the single-request cases. Then toggle the pointer.
  - The pointer changes only on a resolved conflict.
- Output valids follow the selected routing:
  - out_valid1 = (grant1 & ~select) | (grant2 & select).
  - out_valid2 = (grant1 & select) | (grant2 & ~select).
- State XFER:
  - select, grants and valids are held constant; busy=1.
  - Counter decrements each edge.
  - At the edge where the counter is 0: go to IDLE; grants, valids and busy go to 0; done=1 for exactly one cycle.
- Grants are therefore high for exactly PKT_LEN cycles. PKT_LEN=1 gives a one-cycle grant.
- IDLE lasts at least one cycle between transfers. Requests are evaluated only in IDLE; the earliest re-grant is the edge after done rises.
- Requests or destinations changing or dropping during XFER are ignored; the transfer always completes.
- Reset asserted mid-transfer aborts immediately with reset values; no done pulse.
- A request held continuously is re-granted after each IDLE gap.
- Under continuous conflict, grants alternate 1,2,1,2 with one IDLE cycle between each.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req1=1 -> all outputs 0 immediately; after release with req1=1, dest1=0, grant1 rises at the first edge.
- Single source: req1=1, dest1=1, PKT_LEN=4 -> select=1, grant1=1 and out_valid2=1 for exactly 4 cycles; then done=1 for 1 cycle; busy=0.
- Parallel, no conflict: req1=1, dest1=1, req2=1, dest2=0 -> select=1, both grants, both out_valids high for 4 cycles.
- Conflict round-robin: req1=req2=1, dest1=dest2=0 held for 3 transfers -> grant sequence 1,2,1. Source 1 gets select=0; source 2 gets select=1. out_valid1 only; one IDLE cycle between transfers.
- Mid-transfer changes: after grant, drop req1 and flip dest1 -> select and grant1 stay fixed for all 4 cycles; done pulses once.
- Reset mid-XFER at cycle 2 of 4 -> outputs cleared at once, no done; pointer back to source 1 (verify with a subsequent conflict: source 1 wins).

Source files
------------

// File: rtl/crossbar_ctrl.sv
// crossbar_ctrl: arbitrates two sources onto a 2x2 crossbar and holds the routing for a fixed-length transfer
module crossbar_ctrl #(
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req1,
    input  logic dest1,
    input  logic req2,
    input  logic dest2,
    output logic select,
    output logic grant1,
    output logic grant2,
    output logic out_valid1,
    output logic out_valid2,
    output logic busy,
    output logic done
);
    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             conflict;
    logic             n_g1;
    logic             n_g2;
    logic             n_sel;

    // a conflict is resolved in favour of the pointed-to source; otherwise every requester is granted
    always_comb begin
        conflict = req1 & req2 & (dest1 == dest2);
        n_g1     = req1 & ~(conflict & ptr);
        n_g2     = req2 & ~(conflict & ~ptr);
        n_sel    = n_g1 ? dest1 : ~dest2;
    end

    // single FSM: decide routing in IDLE, hold it for PKT_LEN cycles in XFER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= 1'b0;
            select     <= 1'b0;
            grant1     <= 1'b0;
            grant2     <= 1'b0;
            out_valid1 <= 1'b0;
            out_valid2 <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (req1 | req2) begin
                state      <= XFER;
                cnt        <= LAST;
                select     <= n_sel;
                grant1     <= n_g1;
                grant2     <= n_g2;
                out_valid1 <= (n_g1 & ~n_sel) | (n_g2 & n_sel);
                out_valid2 <= (n_g1 & n_sel) | (n_g2 & ~n_sel);
                busy       <= 1'b1;
                if (conflict) ptr <= ~ptr;
            end
        end else if (cnt == '0) begin
            state      <= IDLE;
            grant1     <= 1'b0;
            grant2     <= 1'b0;
            out_valid1 <= 1'b0;
            out_valid2 <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_crossbar_ctrl.sv
// tb_crossbar_ctrl: directed vectors for crossbar_ctrl with PKT_LEN=4
module tb_crossbar_ctrl;
    logic clk = 1'b0;
    logic rst_n, req1, dest1, req2, dest2;
    logic select, grant1, grant2, out_valid1, out_valid2, busy, done;
    int   n_vec = 0;
    int   n_err = 0;

    crossbar_ctrl #(.PKT_LEN(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req1(req1), .dest1(dest1), .req2(req2), .dest2(dest2),
        .select(select), .grant1(grant1), .grant2(grant2),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // output vector order: {select, grant1, grant2, out_valid1, out_valid2, busy, done}
    wire [6:0] o = {select, grant1, grant2, out_valid1, out_valid2, busy, done};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        n_vec++;
        assert (o === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, o, exp);
        end
    endtask

    task automatic hold(input string tag, input int n, input logic [6:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req1 = 1'b0; dest1 = 1'b0; req2 = 1'b0; dest2 = 1'b0;
        tick();
        chk("reset_init", 7'b0000000);
        tick();
        rst_n = 1'b1;

        // async reset mid-cycle while a transfer is running
        req1 = 1'b1; dest1 = 1'b1;
        tick();
        chk("pre_reset_grant", 7'b1100110);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 7'b0000000);
        tick();
        chk("held_in_reset", 7'b0000000);
        dest1 = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("first_grant_after_reset", 7'b0101010);
        req1 = 1'b0;
        hold("reset_xfer", 3, 7'b0101010);
        hold("reset_done", 1, 7'b0000001);
        hold("reset_idle", 1, 7'b0000000);

        // single source to out2
        req1 = 1'b1; dest1 = 1'b1;
        hold("single_c1", 1, 7'b1100110);
        req1 = 1'b0;
        hold("single_xfer", 3, 7'b1100110);
        hold("single_done", 1, 7'b1000001);
        hold("single_idle", 1, 7'b1000000);

        // parallel, no conflict
        req1 = 1'b1; dest1 = 1'b1; req2 = 1'b1; dest2 = 1'b0;
        hold("par_c1", 1, 7'b1111110);
        req1 = 1'b0; req2 = 1'b0;
        hold("par_xfer", 3, 7'b1111110);
        hold("par_done", 1, 7'b1000001);
        hold("par_idle", 1, 7'b1000000);

        // continuous conflict on out1: grants 1,2,1
        req1 = 1'b1; dest1 = 1'b0; req2 = 1'b1; dest2 = 1'b0;
        hold("rr1_xfer", 4, 7'b0101010);
        hold("rr1_done", 1, 7'b0000001);
        hold("rr2_xfer", 4, 7'b1011010);
        hold("rr2_done", 1, 7'b1000001);
        hold("rr3_xfer", 4, 7'b0101010);
        req1 = 1'b0; req2 = 1'b0;
        hold("rr3_done", 1, 7'b0000001);
        hold("rr_idle", 1, 7'b0000000);

        // request and destination changes during XFER are ignored
        req1 = 1'b1; dest1 = 1'b0;
        hold("mid_c1", 1, 7'b0101010);
        req1 = 1'b0; dest1 = 1'b1;
        hold("mid_xfer", 3, 7'b0101010);
        hold("mid_done", 1, 7'b0000001);
        hold("mid_idle", 2, 7'b0000000);

        // pointer now favours source 2; reset at cycle 2 must restore source 1 priority
        req1 = 1'b1; dest1 = 1'b1; req2 = 1'b1; dest2 = 1'b1;
        hold("abort_c1", 2, 7'b0010110);
        #2 rst_n = 1'b0;
        #1 chk("abort_reset", 7'b0000000);
        tick();
        chk("abort_no_done", 7'b0000000);
        rst_n = 1'b1;
        tick();
        chk("ptr_reset_src1_wins", 7'b1100110);
        req1 = 1'b0; req2 = 1'b0;
        hold("post_abort_xfer", 3, 7'b1100110);
        hold("post_abort_done", 1, 7'b1000001);
        hold("post_abort_idle", 1, 7'b1000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
